ula_seq: RTL and testbench

- Multi-cycle sequencer that time-multiplexes the combinational 4-bit ula datapath to execute W-bit operations (W = NIB*NWORDS), one nibble per clock, LSB nibble first.
- Drives the ula input ports, captures ALU_out and C each cycle, ripples the carry between nibbles, and assembles a W-bit result plus whole-word N/C/V/Z flags.
- Sits between a requesting controller (start/done handshake) and a single ula instance.

---
 rtl/ula_seq.sv | 157 +++++++++++++++
 tb/tb_ula_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// Multi-cycle sequencer that runs a W-bit operation through a 4-bit ula one nibble per clock,
// LSB nibble first, rippling the carry for ADD_OP and assembling the result and whole-word flags.
module ula_seq #(
  parameter int         NIB    = 4,
  parameter int         NWORDS = 4,
  parameter logic [1:0] ADD_OP = 2'b10,
  localparam int        W      = NIB * NWORDS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           a_inv,
  input  logic           b_inv,
  input  logic           c_in,
  input  logic [1:0]     alu_op,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic           N,
  output logic           C,
  output logic           V,
  output logic           Z,
  output logic [NIB-1:0] ula_a,
  output logic [NIB-1:0] ula_b,
  output logic           ula_a_inv,
  output logic           ula_b_inv,
  output logic           ula_c_in,
  output logic [1:0]     ula_alu_op,
  input  logic [NIB-1:0] ula_out,
  input  logic           ula_c,
  input  logic           ula_v,
  output logic [1:0]     dbg_state
);

  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: start is sampled only in IDLE; done is a single-cycle pulse and result/flags
  // are valid from that cycle until the next accepted start.

  state_e          state_q, state_d;
  logic [W-1:0]    opa_q, opb_q, result_q;
  logic            ainv_q, binv_q, cin_q, carry_q;
  logic [1:0]      op_q;
  logic [KW-1:0]   k_q;
  logic            n_q, c_q, v_q, z_q;
  logic            last_nib, is_add;
  logic [W-1:0]    final_word;

  assign last_nib   = (k_q == KW'(NWORDS - 1));
  assign is_add     = (op_q == ADD_OP);
  // Full word as it will look after the last nibble lands, used for N and Z.
  assign final_word = {ula_out, result_q[W-NIB-1:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_nib) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    ula_a      = '0;
    ula_b      = '0;
    ula_a_inv  = 1'b0;
    ula_b_inv  = 1'b0;
    ula_c_in   = 1'b0;
    ula_alu_op = 2'b00;
    case (state_q)
      S_RUN: begin
        busy       = 1'b1;
        ula_a      = opa_q[k_q*NIB +: NIB];
        ula_b      = opb_q[k_q*NIB +: NIB];
        ula_a_inv  = ainv_q;
        ula_b_inv  = binv_q;
        ula_c_in   = is_add ? carry_q : cin_q;
        ula_alu_op = op_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q    <= '0;
      opb_q    <= '0;
      ainv_q   <= 1'b0;
      binv_q   <= 1'b0;
      cin_q    <= 1'b0;
      op_q     <= 2'b00;
      k_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            opa_q   <= op_a;
            opb_q   <= op_b;
            ainv_q  <= a_inv;
            binv_q  <= b_inv;
            cin_q   <= c_in;
            op_q    <= alu_op;
            k_q     <= '0;
            carry_q <= c_in;
          end
        end
        S_RUN: begin
          result_q[k_q*NIB +: NIB] <= ula_out;
          carry_q                  <= ula_c;
          if (last_nib) begin
            n_q <= final_word[W-1];
            z_q <= (final_word == '0);
            c_q <= is_add ? ula_c : 1'b0;
            v_q <= is_add ? ula_v : 1'b0;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign N         = n_q;
  assign C         = c_q;
  assign V         = v_q;
  assign Z         = z_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: a behavioural 4-bit ula closes the loop, directed vectors carry
// hand-computed results, and a monitor checks every done pulse against the expected queue.
module tb_ula_seq;

  localparam int NIB = 4;
  localparam int NWORDS = 4;
  localparam int W = 16;
  localparam logic [1:0] ADD = 2'b10;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   op_a, op_b;
  logic           a_inv, b_inv, c_in;
  logic [1:0]     alu_op;
  logic           busy, done;
  logic [W-1:0]   result;
  logic           N, C, V, Z;
  logic [NIB-1:0] ula_a, ula_b;
  logic           ula_a_inv, ula_b_inv, ula_c_in;
  logic [1:0]     ula_alu_op;
  logic [NIB-1:0] ula_out;
  logic           ula_c, ula_v;
  logic [1:0]     dbg_state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [W+3:0] exp_q[$];

  ula_seq #(.NIB(NIB), .NWORDS(NWORDS), .ADD_OP(ADD)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .a_inv(a_inv), .b_inv(b_inv), .c_in(c_in), .alu_op(alu_op),
    .busy(busy), .done(done), .result(result), .N(N), .C(C), .V(V), .Z(Z),
    .ula_a(ula_a), .ula_b(ula_b), .ula_a_inv(ula_a_inv), .ula_b_inv(ula_b_inv),
    .ula_c_in(ula_c_in), .ula_alu_op(ula_alu_op), .ula_out(ula_out),
    .ula_c(ula_c), .ula_v(ula_v), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural ula: carry and overflow always come from the adder, whatever the op.
  logic [NIB-1:0] ea, eb;
  logic [NIB:0]   sum;
  always_comb begin
    ea    = ula_a_inv ? ~ula_a : ula_a;
    eb    = ula_b_inv ? ~ula_b : ula_b;
    sum   = {1'b0, ea} + {1'b0, eb} + {{NIB{1'b0}}, ula_c_in};
    ula_c = sum[NIB];
    ula_v = (ea[NIB-1] == eb[NIB-1]) && (sum[NIB-1] != ea[NIB-1]);
    case (ula_alu_op)
      2'b00:   ula_out = ea & eb;
      2'b01:   ula_out = ea | eb;
      2'b10:   ula_out = sum[NIB-1:0];
      default: ula_out = ea ^ eb;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [W+3:0] e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got result=%0h NCVZ=%b%b%b%b expected no done", result, N, C, V, Z);
      end else begin
        e = exp_q.pop_front();
        if ({result, N, C, V, Z} !== e) begin
          errors++;
          $display("FAIL done_result: got result=%0h NCVZ=%b%b%b%b expected result=%0h NCVZ=%b",
                   result, N, C, V, Z, e[W+3:4], e[3:0]);
        end
      end
    end
  end

  // Driver: issue one op, push its expected response, and check per-cycle ula drive and timing.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ai,
                        input logic bi, input logic ci, input logic [1:0] op,
                        input logic [W-1:0] exp_res, input logic [3:0] exp_ncvz,
                        input bit disturb);
    int cyc;
    int busy_cnt;
    bit seen;
    exp_q.push_back({exp_res, exp_ncvz});
    @(posedge clk); #1;
    op_a = a; op_b = b; a_inv = ai; b_inv = bi; c_in = ci; alu_op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (disturb && (cyc == 2 || cyc == 3)) begin
        start = 1'b1;
        op_a  = 16'hFFFF;
      end else if (disturb && cyc == 4) begin
        start = 1'b0;
      end
      if (done) begin
        chk("latency", cyc, 5);
        chk("busy_cycles", busy_cnt, 5);
        chk("ula_idle_in_done", {ula_a, ula_b, ula_a_inv, ula_b_inv, ula_c_in, ula_alu_op}, 0);
        seen = 1'b1;
        break;
      end
      if (busy && cyc <= NWORDS) begin
        chk("ula_a_nibble", ula_a, a[(cyc-1)*NIB +: NIB]);
        chk("ula_b_nibble", ula_b, b[(cyc-1)*NIB +: NIB]);
        chk("ula_op", {ula_alu_op, ula_a_inv, ula_b_inv}, {op, ai, bi});
        if (op != ADD || cyc == 1) chk("ula_c_in", ula_c_in, ci);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 20 cycles expected done at cycle 5");
    end
    @(negedge clk);
    chk("busy_after_done", {busy, done}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    a_inv = 1'b0; b_inv = 1'b0; c_in = 1'b0; alu_op = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_result_flags", {result, N, C, V, Z}, 0);
    chk("reset_ula_outputs", {ula_a, ula_b, ula_a_inv, ula_b_inv, ula_c_in, ula_alu_op}, 0);
    chk("reset_state", dbg_state, 0);

    //      a        b        ai    bi    ci    op     result   NCVZ     disturb
    run_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'b10, 16'h1000, 4'b0000, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 2'b10, 16'hFFFE, 4'b1000, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'b10, 16'h8000, 4'b1010, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'b10, 16'h0000, 4'b0101, 1'b0);
    run_op(16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b1, 2'b00, 16'h00F0, 4'b0000, 1'b0);
    run_op(16'h1234, 16'h8001, 1'b0, 1'b0, 1'b0, 2'b01, 16'h9235, 4'b1000, 1'b0);
    run_op(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 2'b11, 16'h0000, 4'b0001, 1'b0);
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 2'b10, 16'h3333, 4'b0000, 1'b1);

    // Abort an op with reset while the third nibble is in flight.
    @(posedge clk); #1;
    op_a = 16'h1234; op_b = 16'h1111; a_inv = 1'b0; b_inv = 1'b0; c_in = 1'b0;
    alu_op = ADD; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy_done", {busy, done}, 0);
    chk("abort_result_flags", {result, N, C, V, Z}, 0);
    chk("abort_ula_outputs", {ula_a, ula_b, ula_a_inv, ula_b_inv, ula_c_in, ula_alu_op}, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 2'b10, 16'h0000, 4'b0101, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_pulse_count", done_cnt, 9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
